uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_if.sv | 9 +
 rtl/uart_rx_fifo.sv | 43 ++++
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, oversampling constants and the
// baud-tick divider, common to the receive and (future) transmit paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_A   = 7;
  localparam int SAMPLE_B   = 8;
  localparam int SAMPLE_C   = 9;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int tick_div(input int clk_hz, input int baud);
    longint num;
    longint den;
    num = longint'(clk_hz) + longint'(baud) * 8;
    den = longint'(baud) * OVERSAMPLE;
    return int'(num / den);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-byte stream handshake between the UART receiver and the bus glue.
interface uart_rx_if;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;

  modport master (output o_data, output o_valid, input  i_ready);
  modport slave  (input  o_data, input  o_valid, output i_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO; head is the stored entry at the read pointer, so data
// is visible with no read latency.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       valid,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr, rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        empty, do_pop, do_push;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign valid   = ~empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronize, 16x oversample, 2-of-3 vote at mid-bit,
// and queue received bytes in a small show-ahead FIFO.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic      sys_clk,
  input  logic      reset,
  input  logic      i_rxd,
  uart_rx_if.master rx,
  output logic      o_busy,
  output logic      o_frame_err,
  output logic      o_overrun
);
  localparam int TICK_DIV = tick_div(CLK_HZ, BAUD);
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW       = $clog2(OVERSAMPLE);

  if (TICK_DIV < 2) begin : g_bad_div
    $error("uart_rx: TICK_DIV must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx: FIFO_DEPTH must be a power of 2, minimum 2");
  end

  logic            rxd_s1, rxd, rxd_prev;
  logic [TW-1:0]   tick_cnt;
  logic [SW-1:0]   samp;
  logic            tick, fall, decide, maj;
  logic            sa, sb;
  rx_state_t       state;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            push, pop, full;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      rxd_s1   <= 1'b1;
      rxd      <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_s1   <= i_rxd;
      rxd      <= rxd_s1;
      rxd_prev <= rxd;
    end
  end

  assign fall   = rxd_prev & ~rxd;
  assign tick   = (tick_cnt == TW'(TICK_DIV - 1));
  assign decide = tick && (samp == SW'(SAMPLE_C));
  // Third vote is the live line at the deciding sample.
  assign maj    = (sa & sb) | (sa & rxd) | (sb & rxd);

  // Start edge realigns the oversample phase to the incoming frame.
  always_ff @(posedge sys_clk) begin
    if (reset || (state == IDLE && fall)) begin
      tick_cnt <= '0;
      samp     <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
      samp     <= samp + SW'(1);
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state       <= IDLE;
      bit_idx     <= '0;
      shreg       <= 8'h00;
      sa          <= 1'b1;
      sb          <= 1'b1;
      push        <= 1'b0;
      o_busy      <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      push        <= 1'b0;
      o_frame_err <= 1'b0;
      if (tick && samp == SW'(SAMPLE_A)) sa <= rxd;
      if (tick && samp == SW'(SAMPLE_B)) sb <= rxd;
      case (state)
        IDLE: if (fall) begin
          state  <= START;
          o_busy <= 1'b1;
        end
        START: if (decide) begin
          if (maj) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: if (decide) begin
          shreg <= {maj, shreg[7:1]};
          if (bit_idx == 3'd7) state <= STOP;
          else                 bit_idx <= bit_idx + 3'd1;
        end
        // Returning to IDLE at mid-stop leaves margin for a back-to-back start.
        STOP: if (decide) begin
          if (maj) begin
            push   <= 1'b1;
            state  <= IDLE;
            o_busy <= 1'b0;
          end else begin
            o_frame_err <= 1'b1;
            state       <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: if (rxd) begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  assign pop = rx.o_valid & rx.i_ready;

  always_ff @(posedge sys_clk) begin
    if (reset) o_overrun <= 1'b0;
    else       o_overrun <= push & full & ~pop;
  end

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .push      (push),
    .push_data (shreg),
    .pop       (pop),
    .head      (rx.o_data),
    .valid     (rx.o_valid),
    .full      (full)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives 8N1 frames bit by bit and compares the drained
// byte stream and error pulses against a frame-level model.
module tb_uart_rx;
  localparam int CLK_HZ = 18432000;
  localparam int BAUD   = 115200;
  localparam int DEPTH  = 4;
  localparam int BITC   = 160;           // clocks per bit at TICK_DIV=10
  localparam int FRAME  = 10 * BITC;
  // Push point: 3 cycles to detect the start edge, sample 9 of the stop bit
  // (10 ticks into it) decides, and the FIFO write is the following cycle.
  localparam int PUSH_EDGE = 3 + 9 * BITC + 10 * 10 + 1;

  logic clk = 1'b0;
  logic reset, rxd, busy, fe, ov;
  uart_rx_if bus ();

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .sys_clk     (clk),
    .reset       (reset),
    .i_rxd       (rxd),
    .rx          (bus),
    .o_busy      (busy),
    .o_frame_err (fe),
    .o_overrun   (ov)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, errors = 0;
  int fe_cnt = 0, ov_cnt = 0;
  bit busy_seen = 0;
  logic [7:0] got_q[$];
  logic [7:0] mq[$];

  always @(negedge clk) begin
    if (fe) fe_cnt++;
    if (ov) ov_cnt++;
    if (busy) busy_seen = 1;
  end

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation did not reach the end, at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic line(input logic v, input int n);
    rxd = v;
    step(n);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    line(1'b0, BITC);
    for (int i = 0; i < 8; i++) line(b[i], BITC);
    line(stop, BITC);
  endtask

  // Pops while valid (at most max bytes), one per cycle, recording what it saw.
  task automatic drain(input int max);
    got_q.delete();
    bus.i_ready = 1'b1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!bus.o_valid) break;
      got_q.push_back(bus.o_data);
      @(posedge clk);
      #1;
    end
    bus.i_ready = 1'b0;
    step(1);
  endtask

  task automatic test_reset;
    reset = 1'b1; rxd = 1'b1; bus.i_ready = 1'b0;
    step(5);
    reset = 1'b0;
    step(2);
    @(negedge clk);
    vectors++;
    if (bus.o_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: valid=%b busy=%b want 0 0", bus.o_valid, busy);
    end
    vectors++;
    if (bus.o_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h want 00", bus.o_data);
    end
    vectors++;
    if (fe !== 1'b0 || ov !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses: fe=%b ov=%b want 0 0", fe, ov);
    end
    step(1);
  endtask

  task automatic test_single;
    int t0, rise, fe0, ov0;
    fe0 = fe_cnt; ov0 = ov_cnt; busy_seen = 0;
    rise = -1;
    t0 = cyc;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int k = 0; k < FRAME + 200; k++) begin
          @(negedge clk);
          if (bus.o_valid === 1'b1) begin rise = cyc - t0; break; end
        end
      end
    join
    vectors++;
    if (rise < 9 * BITC + 101 || rise > 9 * BITC + 108) begin
      errors++;
      $display("FAIL single_latency: valid rose %0d clocks after frame start, want %0d..%0d",
               rise, 9 * BITC + 101, 9 * BITC + 108);
    end
    vectors++;
    if (bus.o_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_data: got %h want a5", bus.o_data);
    end
    vectors++;
    if (!busy_seen || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy: seen=%0d now=%b want 1 0", busy_seen, busy);
    end
    vectors++;
    if (fe_cnt != fe0 || ov_cnt != ov0) begin
      errors++;
      $display("FAIL single_pulses: fe=%0d ov=%0d want 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
    drain(8);
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin
      errors++;
      $display("FAIL single_drain: got %0d bytes first %h want 1 a5", got_q.size(),
               got_q.size() ? got_q[0] : 8'hxx);
    end
  endtask

  task automatic test_false_start;
    int fe0;
    fe0 = fe_cnt;
    line(1'b0, 48);
    line(1'b1, 400);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || bus.o_valid !== 1'b0 || fe_cnt != fe0) begin
      errors++;
      $display("FAIL false_start: busy=%b valid=%b fe=%0d want 0 0 0", busy, bus.o_valid,
               fe_cnt - fe0);
    end
    step(1);
    send_frame(8'h3C, 1'b1);
    step(20);
    drain(8);
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== 8'h3C) begin
      errors++;
      $display("FAIL false_start_next: got %0d bytes first %h want 1 3c", got_q.size(),
               got_q.size() ? got_q[0] : 8'hxx);
    end
  endtask

  task automatic test_frame_err;
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    line(1'b0, 500);
    @(negedge clk);
    vectors++;
    if (fe_cnt - fe0 != 1 || bus.o_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL frame_err: pulses=%0d valid=%b busy=%b want 1 0 1", fe_cnt - fe0,
               bus.o_valid, busy);
    end
    step(1);
    line(1'b1, 300);
    send_frame(8'h12, 1'b1);
    step(20);
    drain(8);
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== 8'h12 || fe_cnt - fe0 != 1) begin
      errors++;
      $display("FAIL frame_err_next: got %0d bytes first %h fe=%0d want 1 12 1", got_q.size(),
               got_q.size() ? got_q[0] : 8'hxx, fe_cnt - fe0);
    end
  endtask

  task automatic test_back_to_back;
    int ov0, ov_exp;
    ov0 = ov_cnt; ov_exp = 0;
    mq.delete();
    for (int v = 1; v <= 5; v++) begin
      send_frame(8'(v), 1'b1);
      if (mq.size() < DEPTH) mq.push_back(8'(v));
      else                   ov_exp++;
    end
    step(20);
    vectors++;
    if (ov_cnt - ov0 != ov_exp) begin
      errors++;
      $display("FAIL b2b_overrun: pulses=%0d want %0d", ov_cnt - ov0, ov_exp);
    end
    drain(8);
    vectors++;
    if (got_q != mq) begin
      errors++;
      $display("FAIL b2b_drain: got %0d bytes %p want %p", got_q.size(), got_q, mq);
    end
    vectors++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty: valid=%b want 0", bus.o_valid);
    end
  endtask

  task automatic test_full_pop;
    int ov0;
    logic [7:0] b;
    ov0 = ov_cnt;
    mq.delete();
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1);
      mq.push_back(b);
    end
    fork
      send_frame(8'h77, 1'b1);
      begin
        step(PUSH_EDGE - 1);
        bus.i_ready = 1'b1;
        step(1);
        bus.i_ready = 1'b0;
      end
    join
    void'(mq.pop_front());
    mq.push_back(8'h77);
    step(20);
    vectors++;
    if (ov_cnt != ov0) begin
      errors++;
      $display("FAIL full_pop_overrun: pulses=%0d want 0", ov_cnt - ov0);
    end
    drain(8);
    vectors++;
    if (got_q != mq) begin
      errors++;
      $display("FAIL full_pop_drain: got %p want %p", got_q, mq);
    end
  endtask

  task automatic test_reset_mid;
    int fe0, ov0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    fork
      send_frame(8'hF0, 1'b1);
      begin
        step(5 * BITC + 80);
        reset = 1'b1;
        step(3);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_data !== 8'h00) begin
          errors++;
          $display("FAIL reset_mid_outputs: busy=%b valid=%b data=%h want 0 0 00", busy,
                   bus.o_valid, bus.o_data);
        end
        reset = 1'b0;
      end
    join
    line(1'b1, 200);
    @(negedge clk);
    vectors++;
    if (bus.o_valid !== 1'b0 || fe_cnt != fe0 || ov_cnt != ov0) begin
      errors++;
      $display("FAIL reset_mid_nobyte: valid=%b fe=%0d ov=%0d want 0 0 0", bus.o_valid,
               fe_cnt - fe0, ov_cnt - ov0);
    end
    step(1);
    send_frame(8'h0F, 1'b1);
    step(20);
    drain(8);
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== 8'h0F) begin
      errors++;
      $display("FAIL reset_mid_next: got %0d bytes first %h want 1 0f", got_q.size(),
               got_q.size() ? got_q[0] : 8'hxx);
    end
  endtask

  // Random bytes, occasional bad stop bits, random gaps and random draining.
  task automatic test_random;
    int fe0, ov0, fe_exp, ov_exp, gap;
    logic [7:0] b;
    logic stop;
    fe0 = fe_cnt; ov0 = ov_cnt; fe_exp = 0; ov_exp = 0;
    mq.delete();
    for (int n = 0; n < 10; n++) begin
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 5) != 0);
      send_frame(b, stop);
      if (!stop)                  fe_exp++;
      else if (mq.size() < DEPTH) mq.push_back(b);
      else                        ov_exp++;
      gap = $urandom_range(0, 40) + (stop ? 0 : 20);
      line(1'b1, gap);
      if ($urandom_range(0, 2) == 0) begin
        drain(8);
        vectors++;
        if (got_q != mq) begin
          errors++;
          $display("FAIL random_drain_%0d: got %p want %p", n, got_q, mq);
        end
        mq.delete();
      end
    end
    step(20);
    drain(8);
    vectors++;
    if (got_q != mq) begin
      errors++;
      $display("FAIL random_final: got %p want %p", got_q, mq);
    end
    vectors++;
    if (fe_cnt - fe0 != fe_exp || ov_cnt - ov0 != ov_exp) begin
      errors++;
      $display("FAIL random_pulses: fe=%0d ov=%0d want %0d %0d", fe_cnt - fe0, ov_cnt - ov0,
               fe_exp, ov_exp);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_false_start();
    test_frame_err();
    test_back_to_back();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
